// File: rtl/cordic_wave_pwm_if.sv
//------------------------------------------------------------------------------
// cordic_wave_pwm_if : CORDIC sample bus plus per-channel shaping controls
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cordic_wave_pwm_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
);
  logic signed [WIDTH-1:0]  sin_in;
  logic signed [WIDTH-1:0]  cos_in;
  logic signed [WIDTH-1:0]  angle_in;
  logic                     sample_valid;
  logic [3*CHANNELS-1:0]    wave_sel;
  logic [2*CHANNELS-1:0]    atten;
  logic [CHANNELS-1:0]      enable;

  modport master (
    output sin_in, cos_in, angle_in, sample_valid, wave_sel, atten, enable
  );

  modport slave (
    input  sin_in, cos_in, angle_in, sample_valid, wave_sel, atten, enable
  );
endinterface

`default_nettype wire

// File: rtl/cordic_wave_pwm.sv
//------------------------------------------------------------------------------
// cordic_wave_pwm : multi-channel waveform shaper and double-buffered PWM driver
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_wave_pwm #(
  parameter int WIDTH      = 16,
  parameter int SAMPLE_MSB = 11,
  parameter int PWM_BITS   = 8,
  parameter int CHANNELS   = 2
) (
  input  logic                clock,
  input  logic                resetn,
  cordic_wave_pwm_if.slave    bus,
  output logic [CHANNELS-1:0] pwm,
  output logic                pwm_led,
  output logic                period_start,
  output logic [7:0]          overrun_cnt
);

  localparam logic signed [PWM_BITS-1:0] MAXP = {1'b0, {(PWM_BITS-1){1'b1}}};
  localparam logic signed [PWM_BITS-1:0] MINN = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [PWM_BITS-1:0]        counter;
  logic [PWM_BITS-1:0]        duty     [CHANNELS];
  logic [PWM_BITS-1:0]        pend_val [CHANNELS];
  logic [PWM_BITS-1:0]        duty_new [CHANNELS];
  logic                       pending;
  logic                       load;
  logic [PWM_BITS-1:0]        duty0_next;
  logic                       led_toggle;

  logic signed [PWM_BITS-1:0] sin_f;
  logic signed [PWM_BITS-1:0] cos_f;
  logic signed [PWM_BITS-1:0] ang_f;
  logic                       unused_bits;

  assign sin_f = bus.sin_in[SAMPLE_MSB -: PWM_BITS];
  assign cos_f = bus.cos_in[SAMPLE_MSB -: PWM_BITS];
  assign ang_f = bus.angle_in[SAMPLE_MSB -: PWM_BITS];
  assign unused_bits = ^{bus.sin_in, bus.cos_in, bus.angle_in};

  assign load = (counter == {PWM_BITS{1'b1}});

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [2:0]                sel;
      logic [1:0]                sh;
      logic signed [PWM_BITS-1:0] s;
      logic signed [PWM_BITS-1:0] v;
      logic [PWM_BITS-1:0]       dn;

      always_comb begin
        sel = bus.wave_sel[3*i +: 3];
        sh  = bus.atten[2*i +: 2];
        case (sel)
          3'd0:    s = sin_f;
          3'd1:    s = cos_f;
          // negating the most negative code would wrap, so clamp to full scale
          3'd2:    s = (sin_f == MINN) ? MAXP : -sin_f;
          3'd3:    s = bus.sin_in[WIDTH-1] ? MINN : MAXP;
          3'd4:    s = ang_f;
          default: s = '0;
        endcase
        v  = s >>> sh;
        dn = {~v[PWM_BITS-1], v[PWM_BITS-2:0]};
      end

      assign duty_new[i] = dn;
    end
  endgenerate

  // duty[0] as it will stand after this cycle's load, used for the activity LED
  assign duty0_next = pending ? pend_val[0] : duty[0];
  assign led_toggle = load && bus.enable[0] && (duty0_next != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      counter      <= '0;
      pending      <= 1'b0;
      pwm          <= '0;
      pwm_led      <= 1'b0;
      period_start <= 1'b0;
      overrun_cnt  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i]     <= '0;
        pend_val[i] <= '0;
      end
    end else begin
      counter      <= counter + 1'b1;
      period_start <= load;

      for (int i = 0; i < CHANNELS; i++) begin
        pwm[i] <= bus.enable[i] & (counter < duty[i]);
      end

      if (load && pending) begin
        for (int i = 0; i < CHANNELS; i++) begin
          duty[i] <= pend_val[i];
        end
      end

      if (bus.sample_valid) begin
        for (int i = 0; i < CHANNELS; i++) begin
          pend_val[i] <= duty_new[i];
        end
        pending <= 1'b1;
        // a sample arriving on the load cycle is not dropped: the old one moves to duty
        if (pending && !load && (overrun_cnt != 8'hFF)) begin
          overrun_cnt <= overrun_cnt + 8'd1;
        end
      end else if (load) begin
        pending <= 1'b0;
      end

      if (led_toggle) begin
        pwm_led <= ~pwm_led;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_wave_pwm.sv
//------------------------------------------------------------------------------
// tb_cordic_wave_pwm : directed self-checking bench for cordic_wave_pwm
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cordic_wave_pwm;

  logic       clock  = 1'b0;
  logic       resetn = 1'b1;
  logic [1:0] pwm;
  logic       pwm_led;
  logic       period_start;
  logic [7:0] overrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  cordic_wave_pwm_if #(.WIDTH(16), .CHANNELS(2)) bus ();

  cordic_wave_pwm #(
    .WIDTH(16), .SAMPLE_MSB(11), .PWM_BITS(8), .CHANNELS(2)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .bus          (bus),
    .pwm          (pwm),
    .pwm_led      (pwm_led),
    .period_start (period_start),
    .overrun_cnt  (overrun_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive_sample(input logic [15:0] s, input logic [15:0] c, input logic [15:0] a);
    bus.sin_in       = s;
    bus.cos_in       = c;
    bus.angle_in     = a;
    bus.sample_valid = 1'b1;
    @(negedge clock);
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!period_start && k < 600);
    if (!period_start) check("period_start_timeout", 0, 1);
  endtask

  // Called in a period_start cycle; counts highs over the following full period.
  task automatic measure(output int h0, output int h1, output int ps);
    h0 = 0; h1 = 0; ps = 0;
    repeat (256) begin
      @(negedge clock);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      ps += int'(period_start);
    end
  endtask

  initial begin
    int h0, h1, ps, led_b, hr, ps_early;
    bus.sin_in = '0; bus.cos_in = '0; bus.angle_in = '0;
    bus.sample_valid = 1'b0;
    bus.wave_sel = 6'd0; bus.atten = 4'd0; bus.enable = 2'b11;

    #1 resetn = 1'b0;
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_led", pwm_led, 0);
    check("rst_ps", period_start, 0);
    check("rst_ovr", overrun_cnt, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    // midscale
    drive_sample(16'h0000, 16'h0000, 16'h0000);
    wait_ps();
    led_b = int'(pwm_led);
    measure(h0, h1, ps);
    check("mid_ch0", h0, 128);
    check("mid_ch1", h1, 128);
    check("ps_per_period", ps, 1);
    check("ps_at_end", period_start, 1);
    check("led_toggle", led_b ^ int'(pwm_led), 1);

    // full scale and negated-sine saturation
    drive_sample(16'h07F0, 16'h0000, 16'h0000);
    wait_ps(); measure(h0, h1, ps);
    check("full_ch0", h0, 255);
    bus.wave_sel = {3'd2, 3'd0};
    drive_sample(16'hF800, 16'h0000, 16'h0000);
    wait_ps(); measure(h0, h1, ps);
    check("minn_ch0", h0, 0);
    check("neg_sat_ch1", h1, 255);

    // attenuation, positive and negative
    bus.wave_sel = {3'd1, 3'd0};
    bus.atten    = {2'd1, 2'd2};
    drive_sample(16'h07F0, 16'hFC00, 16'h0000);
    wait_ps(); measure(h0, h1, ps);
    check("atten2_ch0", h0, 159);
    check("cos_atten1_ch1", h1, 96);

    // square, silence, sawtooth
    bus.atten    = 4'd0;
    bus.wave_sel = {3'd6, 3'd3};
    drive_sample(16'h0010, 16'h0000, 16'h0000);
    wait_ps(); measure(h0, h1, ps);
    check("square_pos", h0, 255);
    check("silence_ch1", h1, 128);
    bus.wave_sel = {3'd4, 3'd3};
    drive_sample(16'hFFF0, 16'h0000, 16'h0200);
    wait_ps(); measure(h0, h1, ps);
    check("square_neg", h0, 0);
    check("saw_ch1", h1, 160);

    // disabled channel
    bus.enable = 2'b01;
    measure(h0, h1, ps);
    check("disabled_ch1", h1, 0);
    bus.enable = 2'b11;

    // overrun: three strobes in one period, newest wins
    bus.wave_sel = 6'd0;
    drive_sample(16'h0100, 16'h0000, 16'h0000);
    drive_sample(16'h0200, 16'h0000, 16'h0000);
    drive_sample(16'h0300, 16'h0000, 16'h0000);
    check("overrun_2", overrun_cnt, 2);
    wait_ps(); measure(h0, h1, ps);
    check("newest_wins", h0, 176);

    // strobe on the load cycle: no overrun, applies a period later
    drive_sample(16'h0400, 16'h0000, 16'h0000);
    repeat (254) @(negedge clock);
    drive_sample(16'h0500, 16'h0000, 16'h0000);
    check("load_aligned", period_start, 1);
    check("load_no_overrun", overrun_cnt, 2);
    measure(h0, h1, ps);
    check("old_pending", h0, 192);
    measure(h0, h1, ps);
    check("late_pending", h0, 208);
    check("overrun_hold", overrun_cnt, 2);

    // async reset mid-period
    drive_sample(16'h07F0, 16'h0000, 16'h0000);
    wait_ps();
    repeat (100) @(negedge clock);
    check("pre_reset_pwm", pwm[0], 1);
    #2 resetn = 1'b0;
    #1;
    check("async_pwm", pwm, 0);
    check("async_led", pwm_led, 0);
    check("async_ps", period_start, 0);
    check("async_ovr", overrun_cnt, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    hr = 0; ps_early = 0;
    repeat (255) begin
      @(negedge clock);
      hr += int'(pwm[0]);
      ps_early += int'(period_start);
    end
    @(negedge clock);
    hr += int'(pwm[0]);
    check("post_reset_pwm_low", hr, 0);
    check("post_reset_no_early_ps", ps_early, 0);
    check("post_reset_first_ps", period_start, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/cordic_wave_pwm.md
Name: cordic_wave_pwm

Overview:
Multi-channel waveform shaper and PWM driver fed by the CORDIC sine/cosine/angle outputs. Each channel selects a waveform, attenuates it, converts it to offset binary and drives a PWM pin. Duty updates are double-buffered so they apply only at PWM period boundaries. Replaces the single-channel, sine/cosine-only PWM path and adds attenuation, extra waveforms, per-channel enable and overrun accounting.

Parameters:
WIDTH, 16, width of the signed CORDIC inputs
SAMPLE_MSB, 11, MSB index of the CORDIC field used as the sample
PWM_BITS, 8, PWM resolution, sample width and counter width; field is [SAMPLE_MSB -: PWM_BITS]
CHANNELS, 2, number of independent PWM channels

Ports:
clock  in  1  system clock, all logic on the rising edge
resetn  in  1  asynchronous active-low reset
sin_in  in  WIDTH  signed CORDIC sine
cos_in  in  WIDTH  signed CORDIC cosine
angle_in  in  WIDTH  signed CORDIC angle
sample_valid  in  1  one-cycle strobe: inputs valid
wave_sel  in  3*CHANNELS  per-channel code, ch i at [3i+2:3i]
atten  in  2*CHANNELS  per-channel arithmetic right shift 0..3
enable  in  CHANNELS  per-channel PWM output enable
pwm  out  CHANNELS  registered PWM outputs
pwm_led  out  1  activity toggle
period_start  out  1  one-cycle pulse on the first cycle of each PWM period
overrun_cnt  out  8  saturating count of dropped samples

Behaviour:
- Reset (async, resetn=0): pwm=0, pwm_led=0, period_start=0, overrun_cnt=0, counter=0, all duty=0, all pending values=0, pending flag=0.
- Field extraction: s = signed field [SAMPLE_MSB -: PWM_BITS] of the selected input. Let P=PWM_BITS, MAXP=2^(P-1)-1, MINN=-2^(P-1).
- wave_sel codes:
  - 0: sine
  - 1: cosine
  - 2: negated sine; -MINN saturates to MAXP
  - 3: square; MAXP when sin_in[WIDTH-1]=0, else MINN
  - 4: sawtooth from the angle_in field
  - 5..7: silence, value 0
- Shaping: v = s >>> atten (arithmetic shift). duty_new = v with its MSB inverted (offset binary).
- Pending buffer:
  - On sample_valid, every channel's duty_new is written to its pending register and pending flag=1.
  - wave_sel and atten are sampled only on sample_valid.
- Counter: P-bit free-running counter, increments every cycle, wraps from 2^P-1 to 0.
- Load cycle (counter=2^P-1):
  - If pending=1: each duty <= pending value, and pending clears unless sample_valid is also high.
  - Simultaneous sample_valid on a load cycle: the old pending value transfers to duty, the new value is written to pending, pending stays 1, no overrun.
- Overrun: sample_valid while pending=1 and not a load cycle overwrites pending (newest wins) and increments overrun_cnt, saturating at 255.
- pwm[i] <= enable[i] & (counter < duty[i]), registered, 1-cycle latency from counter.
  - duty 0 gives constant low; duty 2^P-1 gives 2^P-1 high cycles out of 2^P.
  - enable low forces pwm low on the next cycle; duty keeps updating.
- period_start <= (counter == 2^P-1), so it is high in the cycle counter=0.
- pwm_led: toggles on each load cycle where the duty[0] value after the load is nonzero and enable[0]=1.
- Reset mid-period: outputs drop immediately (async). After release, counter restarts at 0 and the first period runs at duty 0.

Test Plan:
(All with defaults, ch0 wave_sel=0, atten=0, enable=2'b11.)
1. sin_in=16'h0000, sample_valid -> duty0=0x80 from next period; pwm[0] high 128 of 256 cycles; period_start every 256 cycles; pwm_led toggles each period.
2. sin_in=16'h07F0 (field 0x7F) -> duty0=0xFF, pwm[0] high 255 of 256. With sin_in=16'hF800, ch1 wave_sel=2 -> duty0=0 (pwm[0] always low), duty1=0xFF (saturated).
3. sin_in=16'h07F0, atten0=2 -> field 0x1F -> duty0=0x9F, pwm[0] high 159 cycles per period.
4. ch0 wave_sel=3: sin_in=16'h0010 -> duty0=0xFF; sin_in=16'hFFF0 -> duty0=0x00. ch1 wave_sel=6 -> duty1=0x80.
5. Three sample_valid strobes mid-period (values 0x10, 0x20, 0x30 in the field) -> only 0x30 applied (duty 0xB0) at the next load, overrun_cnt=2. sample_valid on the load cycle -> overrun_cnt unchanged, value applied one period later.
6. resetn low for 3 cycles mid-period with duty0=0xFF -> pwm, pwm_led, period_start and overrun_cnt go to 0 asynchronously. After release pwm stays low for 256 cycles; first period_start arrives 256 cycles after release.
